// File: rtl/dpi_stream_ctx_mgr.sv
`default_nettype none
// ============================================================================
// Module      : dpi_stream_ctx_mgr
// Description : Per-stream context manager for one regex DFA lane. It saves
//               and restores the DFA state of every stream ID across packets
//               and keeps a saturating per-stream match count. The DFA sits
//               outside the block, behind a state-load/char port pair.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               pkt_start/stream_id/
//               new_stream/enable           - packet start and its attributes
//               char_in/char_vld/eop        - payload byte stream
//               clr_req/clr_stream          - invalidate one stream context
//               busy/proto_err              - packet in progress / start while busy
//               dfa_char/dfa_char_vld       - registered byte to the DFA
//               dfa_state_ld/_val           - DFA state load pulse and value
//               dfa_state/dfa_accept        - DFA current state and accept
//               res_vld/res_stream/
//               res_match/res_count         - per-packet result pulse
// Revision    : 1.0 - initial release
// ============================================================================
module dpi_stream_ctx_mgr #(
    parameter int STATE_W  = 11,
    parameter int STREAM_W = 6,
    parameter int COUNT_W  = 16,
    parameter int DFA_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pkt_start,
    input  logic [STREAM_W-1:0] stream_id,
    input  logic                new_stream,
    input  logic                enable,
    input  logic [7:0]          char_in,
    input  logic                char_vld,
    input  logic                eop,
    input  logic                clr_req,
    input  logic [STREAM_W-1:0] clr_stream,
    output logic                busy,
    output logic                proto_err,
    output logic [7:0]          dfa_char,
    output logic                dfa_char_vld,
    output logic                dfa_state_ld,
    output logic [STATE_W-1:0]  dfa_state_ld_val,
    input  logic [STATE_W-1:0]  dfa_state,
    input  logic                dfa_accept,
    output logic                res_vld,
    output logic [STREAM_W-1:0] res_stream,
    output logic                res_match,
    output logic [COUNT_W-1:0]  res_count
);

    localparam int NSTREAMS = 2**STREAM_W;
    localparam int DRAIN_W  = $clog2(DFA_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DFA_LAT);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [STREAM_W-1:0]   id_q, id_d;
    logic                  en_q, en_d;
    logic                  fresh_q, fresh_d;
    logic                  match_q, match_d;
    logic [COUNT_W-1:0]    base_q, base_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic [NSTREAMS-1:0]   ctx_vld_q, ctx_vld_d;
    logic [7:0]            dfa_char_q, dfa_char_d;
    logic                  dfa_char_vld_q, dfa_char_vld_d;
    logic                  res_vld_q, res_vld_d;
    logic [STREAM_W-1:0]   res_stream_q, res_stream_d;
    logic                  res_match_q, res_match_d;
    logic [COUNT_W-1:0]    res_count_q, res_count_d;

    // Context storage: no reset, validity is tracked by ctx_vld_q alone.
    logic [STATE_W-1:0]    state_mem [NSTREAMS];
    logic [COUNT_W-1:0]    count_mem [NSTREAMS];

    logic [COUNT_W-1:0]    new_count;
    logic                  commit_wr;

    // A packet contributes at most one to the count, and never wraps.
    assign new_count = (base_q == COUNT_MAX) ? base_q : base_q + COUNT_W'(match_q);

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        en_d           = en_q;
        fresh_d        = fresh_q;
        match_d        = match_q;
        base_d         = base_q;
        drain_d        = drain_q;
        ctx_vld_d      = ctx_vld_q;
        dfa_char_d     = dfa_char_q;
        dfa_char_vld_d = 1'b0;
        res_vld_d      = 1'b0;
        res_stream_d   = res_stream_q;
        res_match_d    = res_match_q;
        res_count_d    = res_count_q;
        commit_wr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_start) begin
                    id_d    = stream_id;
                    en_d    = enable;
                    fresh_d = new_stream | ~ctx_vld_q[stream_id];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                base_d  = fresh_q ? '0 : count_mem[id_q];
                match_d = 1'b0;
                drain_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (char_vld) begin
                    dfa_char_vld_d = 1'b1;
                    dfa_char_d     = char_in;
                end
                if (dfa_accept) begin
                    match_d = 1'b1;
                end
                if (eop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait until the accept of the last forwarded byte has arrived.
                if (dfa_accept) begin
                    match_d = 1'b1;
                end
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_COMMIT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_COMMIT: begin
                res_vld_d    = 1'b1;
                res_stream_d = id_q;
                res_match_d  = en_q & match_q;
                res_count_d  = en_q ? new_count : base_q;
                if (en_q) begin
                    commit_wr       = 1'b1;
                    ctx_vld_d[id_q] = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Applied last so a clear beats a same-cycle commit to that stream.
        if (clr_req) begin
            ctx_vld_d[clr_stream] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            id_q           <= '0;
            en_q           <= 1'b0;
            fresh_q        <= 1'b0;
            match_q        <= 1'b0;
            base_q         <= '0;
            drain_q        <= '0;
            ctx_vld_q      <= '0;
            dfa_char_q     <= '0;
            dfa_char_vld_q <= 1'b0;
            res_vld_q      <= 1'b0;
            res_stream_q   <= '0;
            res_match_q    <= 1'b0;
            res_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            en_q           <= en_d;
            fresh_q        <= fresh_d;
            match_q        <= match_d;
            base_q         <= base_d;
            drain_q        <= drain_d;
            ctx_vld_q      <= ctx_vld_d;
            dfa_char_q     <= dfa_char_d;
            dfa_char_vld_q <= dfa_char_vld_d;
            res_vld_q      <= res_vld_d;
            res_stream_q   <= res_stream_d;
            res_match_q    <= res_match_d;
            res_count_q    <= res_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            state_mem[id_q] <= dfa_state;
            count_mem[id_q] <= new_count;
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign proto_err        = pkt_start & busy;
    assign dfa_state_ld     = (state_q == S_LOAD);
    assign dfa_state_ld_val = (state_q == S_LOAD && !fresh_q) ? state_mem[id_q] : '0;
    assign dfa_char         = dfa_char_q;
    assign dfa_char_vld     = dfa_char_vld_q;
    assign res_vld          = res_vld_q;
    assign res_stream       = res_stream_q;
    assign res_match        = res_match_q;
    assign res_count        = res_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dpi_stream_ctx_mgr.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpi_stream_ctx_mgr
// Description : Directed self-checking bench for dpi_stream_ctx_mgr with a
//               one-cycle-latency DFA model that accepts on "USER".
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpi_stream_ctx_mgr;

    localparam int STATE_W  = 11;
    localparam int STREAM_W = 6;
    localparam int COUNT_W  = 2;
    localparam int DFA_LAT  = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                pkt_start;
    logic [STREAM_W-1:0] stream_id;
    logic                new_stream;
    logic                enable;
    logic [7:0]          char_in;
    logic                char_vld;
    logic                eop;
    logic                clr_req;
    logic [STREAM_W-1:0] clr_stream;
    logic                busy;
    logic                proto_err;
    logic [7:0]          dfa_char;
    logic                dfa_char_vld;
    logic                dfa_state_ld;
    logic [STATE_W-1:0]  dfa_state_ld_val;
    logic [STATE_W-1:0]  dfa_state;
    logic                dfa_accept;
    logic                res_vld;
    logic [STREAM_W-1:0] res_stream;
    logic                res_match;
    logic [COUNT_W-1:0]  res_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpi_stream_ctx_mgr #(
        .STATE_W (STATE_W),
        .STREAM_W(STREAM_W),
        .COUNT_W (COUNT_W),
        .DFA_LAT (DFA_LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pkt_start       (pkt_start),
        .stream_id       (stream_id),
        .new_stream      (new_stream),
        .enable          (enable),
        .char_in         (char_in),
        .char_vld        (char_vld),
        .eop             (eop),
        .clr_req         (clr_req),
        .clr_stream      (clr_stream),
        .busy            (busy),
        .proto_err       (proto_err),
        .dfa_char        (dfa_char),
        .dfa_char_vld    (dfa_char_vld),
        .dfa_state_ld    (dfa_state_ld),
        .dfa_state_ld_val(dfa_state_ld_val),
        .dfa_state       (dfa_state),
        .dfa_accept      (dfa_accept),
        .res_vld         (res_vld),
        .res_stream      (res_stream),
        .res_match       (res_match),
        .res_count       (res_count)
    );

    // DFA model: states 0..4 track progress through "USER", state 4 accepts.
    // dfa_accept pulses in the cycle after the byte that reaches state 4.
    function automatic logic [STATE_W-1:0] nxt(input logic [STATE_W-1:0] s, input logic [7:0] c);
        logic ok;
        case (s)
            11'd0:   ok = (c == 8'h55);
            11'd1:   ok = (c == 8'h53);
            11'd2:   ok = (c == 8'h45);
            11'd3:   ok = (c == 8'h52);
            default: ok = 1'b0;
        endcase
        if (ok)               return s + 11'd1;
        else if (c == 8'h55)  return 11'd1;
        else                  return 11'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfa_state  <= '0;
            dfa_accept <= 1'b0;
        end else if (dfa_state_ld) begin
            dfa_state  <= dfa_state_ld_val;
            dfa_accept <= 1'b0;
        end else if (dfa_char_vld) begin
            dfa_state  <= nxt(dfa_state, dfa_char);
            dfa_accept <= (nxt(dfa_state, dfa_char) == 11'd4);
        end else begin
            dfa_accept <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One packet: pkt_start now, LOAD check, bytes from T+2 with eop on the
    // last, then the result pulse expected DFA_LAT+3 cycles after eop.
    task automatic run_pkt(input logic [STREAM_W-1:0] sid, input logic ns, input logic en,
                           input string s, input int perr_at, input logic clr_commit,
                           input int exp_ld, input int exp_match, input int exp_cnt,
                           input string tag);
        int cyc;
        pkt_start = 1'b1; stream_id = sid; new_stream = ns; enable = en;
        @(posedge clk); #1;
        pkt_start = 1'b0; new_stream = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk({tag, ".ld"},     32'(dfa_state_ld), 32'd1);
        chk({tag, ".ld_val"}, 32'(dfa_state_ld_val), 32'(exp_ld));
        chk({tag, ".busy"},   32'(busy), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < s.len(); i++) begin
            char_in   = s[i];
            char_vld  = 1'b1;
            eop       = (i == s.len() - 1);
            pkt_start = (i == perr_at);
            stream_id = (i == perr_at) ? (sid ^ 6'h01) : sid;
            @(negedge clk);
            if (i == perr_at)
                chk({tag, ".perr_hi"}, 32'(proto_err), 32'd1);
            else if (perr_at >= 0 && i == perr_at + 1)
                chk({tag, ".perr_lo"}, 32'(proto_err), 32'd0);
            @(posedge clk); #1;
        end
        pkt_start = 1'b0; stream_id = sid; char_vld = 1'b0; eop = 1'b0;
        cyc = 1;
        while (cyc < 20) begin
            if (clr_commit && cyc == DFA_LAT + 2) begin
                clr_req = 1'b1; clr_stream = sid;
            end else begin
                clr_req = 1'b0;
            end
            @(negedge clk);
            if (res_vld === 1'b1) break;
            @(posedge clk); #1;
            cyc++;
        end
        clr_req = 1'b0;
        chk({tag, ".latency"}, 32'(cyc), 32'(DFA_LAT + 3));
        chk({tag, ".stream"},  32'(res_stream), 32'(sid));
        chk({tag, ".match"},   32'(res_match), 32'(exp_match));
        chk({tag, ".count"},   32'(res_count), 32'(exp_cnt));
        chk({tag, ".idle"},    32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        pkt_start = 1'b0; stream_id = '0; new_stream = 1'b0; enable = 1'b0;
        char_in = '0; char_vld = 1'b0; eop = 1'b0; clr_req = 1'b0; clr_stream = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy",      32'(busy), 32'd0);
        chk("rst.proto_err", 32'(proto_err), 32'd0);
        chk("rst.dfa_char",  32'(dfa_char), 32'd0);
        chk("rst.dfa_vld",   32'(dfa_char_vld), 32'd0);
        chk("rst.ld",        32'(dfa_state_ld), 32'd0);
        chk("rst.ld_val",    32'(dfa_state_ld_val), 32'd0);
        chk("rst.res_vld",   32'(res_vld), 32'd0);
        chk("rst.res_match", 32'(res_match), 32'd0);
        chk("rst.res_count", 32'(res_count), 32'd0);
        chk("rst.res_strm",  32'(res_stream), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh stream 5, match in the middle of the payload.
        run_pkt(6'd5, 1'b1, 1'b1, "USER x", -1, 1'b0, 0, 1, 1, "s5_first");
        // Pattern split across two packets; the second one restores state 2.
        run_pkt(6'd5, 1'b0, 1'b1, "US",     -1, 1'b0, 0, 0, 1, "s5_us");
        run_pkt(6'd5, 1'b0, 1'b1, "ER",     -1, 1'b0, 2, 1, 2, "s5_er");
        // Disabled packet: reported count is the base, nothing written back.
        run_pkt(6'd5, 1'b0, 1'b0, "USERU",  -1, 1'b0, 4, 0, 2, "s5_dis");
        run_pkt(6'd5, 1'b0, 1'b1, "x",      -1, 1'b0, 4, 0, 2, "s5_after_dis");

        // Saturating count on a 2-bit counter.
        run_pkt(6'd3, 1'b1, 1'b1, "USER",   -1, 1'b0, 0, 1, 1, "s3_p1");
        run_pkt(6'd3, 1'b0, 1'b1, "USER",   -1, 1'b0, 4, 1, 2, "s3_p2");
        run_pkt(6'd3, 1'b0, 1'b1, "USER",   -1, 1'b0, 4, 1, 3, "s3_p3");
        run_pkt(6'd3, 1'b0, 1'b1, "USER",   -1, 1'b0, 4, 1, 3, "s3_p4");
        // Clear in the commit cycle wins; the next packet starts fresh.
        run_pkt(6'd3, 1'b0, 1'b1, "USER",   -1, 1'b1, 4, 1, 3, "s3_clr");
        run_pkt(6'd3, 1'b0, 1'b1, "US",     -1, 1'b0, 0, 0, 0, "s3_fresh");

        // pkt_start during RUN pulses proto_err, result is untouched.
        run_pkt(6'd7, 1'b1, 1'b1, "USER",    1, 1'b0, 0, 1, 1, "s7_perr");

        // Async reset mid-packet drops all contexts.
        run_pkt(6'd9, 1'b1, 1'b1, "USERU",  -1, 1'b0, 0, 1, 1, "s9_pre");
        pkt_start = 1'b1; stream_id = 6'd9; new_stream = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        @(posedge clk); #1;
        char_in = 8'h55; char_vld = 1'b1;
        @(posedge clk); #1;
        char_in = 8'h53;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy",    32'(busy), 32'd0);
        chk("arst.dfa_vld", 32'(dfa_char_vld), 32'd0);
        chk("arst.dfa_chr", 32'(dfa_char), 32'd0);
        chk("arst.ld",      32'(dfa_state_ld), 32'd0);
        chk("arst.res_vld", 32'(res_vld), 32'd0);
        char_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("arst.no_res", 32'(res_vld), 32'd0);
        end
        run_pkt(6'd9, 1'b0, 1'b1, "x",      -1, 1'b0, 0, 0, 0, "s9_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
